// File: rtl/trailing_ones_counter_if.sv
// Handshake bundle for trailing_ones_counter: word input channel and count output channel.
// The slave modport is the counter's view; the master modport is the producer/consumer view.
interface trailing_ones_counter_if #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 4
);
  logic [WORD_WIDTH-1:0]  word_in;
  logic                   word_in_valid;
  logic                   word_in_ready;
  logic [COUNT_WIDTH-1:0] count_out;
  logic                   all_ones_out;
  logic                   count_out_valid;
  logic                   count_out_ready;

  modport master (
    output word_in,
    output word_in_valid,
    input  word_in_ready,
    input  count_out,
    input  all_ones_out,
    input  count_out_valid,
    output count_out_ready
  );

  modport slave (
    input  word_in,
    input  word_in_valid,
    output word_in_ready,
    output count_out,
    output all_ones_out,
    output count_out_valid,
    input  count_out_ready
  );
endinterface

// File: rtl/trailing_ones_counter.sv
// Multicycle trailing-ones counter, STEP_WIDTH bits examined per COUNT cycle.
// Optional feature macro: TRAILING_ONES_COUNTER_EARLY_EXIT_EN -- stop scanning at the first chunk
// that is not all ones. Without it every word takes WORD_WIDTH/STEP_WIDTH cycles.
module trailing_ones_counter #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned STEP_WIDTH  = 2,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input logic                    clock,
  input logic                    clear,
  trailing_ones_counter_if.slave bus
);
  localparam int unsigned NUM_CHUNKS      = WORD_WIDTH / STEP_WIDTH;
  localparam int unsigned CHUNK_CNT_WIDTH = $clog2(NUM_CHUNKS + 1);

  localparam logic [COUNT_WIDTH-1:0]     STEP_INC    = COUNT_WIDTH'(STEP_WIDTH);
  localparam logic [COUNT_WIDTH-1:0]     WORD_CNT    = COUNT_WIDTH'(WORD_WIDTH);
  localparam logic [CHUNK_CNT_WIDTH-1:0] CHUNKS_INIT = CHUNK_CNT_WIDTH'(NUM_CHUNKS);
  localparam logic [CHUNK_CNT_WIDTH-1:0] CHUNK_ONE   = CHUNK_CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e                     state_q, state_d;
  logic [WORD_WIDTH-1:0]      shift_q, shift_d;
  logic [COUNT_WIDTH-1:0]     acc_q, acc_d;
  logic [CHUNK_CNT_WIDTH-1:0] chunks_q, chunks_d;
  logic [COUNT_WIDTH-1:0]     count_q, count_d;
  logic                       all_ones_q, all_ones_d;

  logic [STEP_WIDTH-1:0]  chunk;
  logic                   chunk_full;
  logic [COUNT_WIDTH-1:0] chunk_ones;
  logic                   chunk_run;
  logic [COUNT_WIDTH-1:0] chunk_add;
  logic [COUNT_WIDTH-1:0] acc_sum;
  logic                   last_chunk;

  assign chunk      = shift_q[STEP_WIDTH-1:0];
  assign chunk_full = &chunk;
  assign acc_sum    = acc_q + chunk_add;

  // Trailing-ones count of the current (not all-ones) chunk.
  always_comb begin
    chunk_ones = '0;
    chunk_run  = 1'b1;
    for (int i = 0; i < STEP_WIDTH; i++) begin
      if (chunk_run && chunk[i]) begin
        chunk_ones = chunk_ones + COUNT_WIDTH'(1);
      end else begin
        chunk_run = 1'b0;
      end
    end
  end

`ifdef TRAILING_ONES_COUNTER_EARLY_EXIT_EN
  assign chunk_add  = chunk_full ? STEP_INC : chunk_ones;
  assign last_chunk = !chunk_full || (chunks_q == CHUNK_ONE);
`else
  // Set once a broken chunk is seen; later chunks then contribute nothing.
  logic final_q, final_d;

  assign chunk_add  = final_q ? '0 : (chunk_full ? STEP_INC : chunk_ones);
  assign last_chunk = (chunks_q == CHUNK_ONE);

  // Next value of the result-final flag.
  always_comb begin
    final_d = final_q;
    if (state_q == StIdle) begin
      final_d = 1'b0;
    end else if (state_q == StCount && !chunk_full) begin
      final_d = 1'b1;
    end
  end

  // Result-final flag register.
  always_ff @(posedge clock) begin
    if (clear) begin
      final_q <= 1'b0;
    end else begin
      final_q <= final_d;
    end
  end
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    chunks_d   = chunks_q;
    count_d    = count_q;
    all_ones_d = all_ones_q;
    unique case (state_q)
      StIdle: begin
        if (bus.word_in_valid) begin
          state_d  = StCount;
          shift_d  = bus.word_in;
          acc_d    = '0;
          chunks_d = CHUNKS_INIT;
        end
      end
      StCount: begin
        acc_d    = acc_sum;
        shift_d  = shift_q >> STEP_WIDTH;
        chunks_d = chunks_q - CHUNK_ONE;
        if (last_chunk) begin
          state_d    = StDone;
          count_d    = acc_sum;
          all_ones_d = (acc_sum == WORD_CNT);
        end
      end
      StDone: begin
        if (bus.count_out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; clear discards any in-flight word.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      acc_q      <= '0;
      chunks_q   <= '0;
      count_q    <= '0;
      all_ones_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      chunks_q   <= chunks_d;
      count_q    <= count_d;
      all_ones_q <= all_ones_d;
    end
  end

  assign bus.word_in_ready   = (state_q == StIdle);
  assign bus.count_out_valid = (state_q == StDone);
  assign bus.count_out       = count_q;
  assign bus.all_ones_out    = all_ones_q;
endmodule

// File: tb/tb_trailing_ones_counter.sv
// Self-checking bench for trailing_ones_counter: directed cases plus randomized words checked
// against a bit-walking reference model of count and latency.
module tb_trailing_ones_counter;
  localparam int WORD_WIDTH  = 8;
  localparam int STEP_WIDTH  = 2;
  localparam int COUNT_WIDTH = 4;
  localparam int NUM_CHUNKS  = WORD_WIDTH / STEP_WIDTH;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  trailing_ones_counter_if #(.WORD_WIDTH(WORD_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) bus ();

  trailing_ones_counter #(
    .WORD_WIDTH (WORD_WIDTH),
    .STEP_WIDTH (STEP_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int ref_count(input logic [WORD_WIDTH-1:0] w);
    int c = 0;
    while (c < WORD_WIDTH && w[c]) c++;
    return c;
  endfunction

  function automatic int ref_latency(input int c);
`ifdef TRAILING_ONES_COUNTER_EARLY_EXIT_EN
    int n = c / STEP_WIDTH + 1;
    return (n < NUM_CHUNKS) ? n : NUM_CHUNKS;
`else
    return NUM_CHUNKS + 0 * c;
`endif
  endfunction

  // Offer one word, wait for its result, optionally stall the consumer, then complete.
  task automatic send_word(input logic [WORD_WIDTH-1:0] w, input int hold, input string tag);
    int c   = ref_count(w);
    int lat = 0;
    check({tag, ".ready_idle"}, int'(bus.word_in_ready), 1);
    bus.word_in         = w;
    bus.word_in_valid   = 1'b1;
    bus.count_out_ready = (hold == 0);
    step();
    bus.word_in_valid = 1'b0;
    while (!bus.count_out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, ref_latency(c));
    check({tag, ".count"}, int'(bus.count_out), c);
    check({tag, ".all_ones"}, int'(bus.all_ones_out), int'(c == WORD_WIDTH));
    for (int i = 0; i < hold; i++) begin
      bus.word_in       = ~w;
      bus.word_in_valid = 1'b1;
      step();
      check({tag, ".hold_valid"}, int'(bus.count_out_valid), 1);
      check({tag, ".hold_count"}, int'(bus.count_out), c);
      check({tag, ".hold_ready"}, int'(bus.word_in_ready), 0);
    end
    bus.word_in_valid   = 1'b0;
    bus.count_out_ready = 1'b1;
    step();
    check({tag, ".ready_after"}, int'(bus.word_in_ready), 1);
    check({tag, ".valid_after"}, int'(bus.count_out_valid), 0);
  endtask

  initial begin
    bus.word_in         = '0;
    bus.word_in_valid   = 1'b0;
    bus.count_out_ready = 1'b1;

    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
    check("reset.ready", int'(bus.word_in_ready), 1);
    check("reset.valid", int'(bus.count_out_valid), 0);
    check("reset.count", int'(bus.count_out), 0);
    check("reset.all_ones", int'(bus.all_ones_out), 0);

    send_word(8'b1010_1111, 0, "w_af");
    send_word(8'hFF, 0, "w_ff");
    send_word(8'h00, 0, "w_00");
    send_word(8'h01, 0, "w_01");
    send_word(8'b0011_0111, 5, "backpressure");

    // Clear on the second COUNT cycle of 0xFF.
    bus.word_in       = 8'hFF;
    bus.word_in_valid = 1'b1;
    step();
    bus.word_in_valid = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear.ready", int'(bus.word_in_ready), 1);
    check("clear.count", int'(bus.count_out), 0);
    check("clear.all_ones", int'(bus.all_ones_out), 0);
    for (int i = 0; i < 6; i++) begin
      check("clear.no_valid", int'(bus.count_out_valid), 0);
      step();
    end
    send_word(8'h03, 0, "after_clear");

    // Random words, biased towards a chosen trailing-ones length.
    for (int n = 0; n < 40; n++) begin
      logic [WORD_WIDTH-1:0] w;
      int k;
      w = WORD_WIDTH'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, WORD_WIDTH);
        for (int b = 0; b < WORD_WIDTH; b++) begin
          if (b < k) w[b] = 1'b1;
          else if (b == k) w[b] = 1'b0;
        end
      end
      send_word(w, $urandom_range(0, 2), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
